// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage:
// funct3 access encodings, default depth, W bundle.
package memory_stage_pkg;

  localparam int DEPTH_DEF = 256;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef struct packed {
    logic        regwrite;
    logic        resultsrc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic        misalign;
  } mw_t;

  function automatic logic [3:0] lane_mask(
    input size_e      sz,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (sz)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM: byte-enabled
// synchronous write, combinational read.
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // write enabled byte lanes at the clock edge
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/memory_stage.sv
// M stage: data memory access, load extract,
// and the M/W pipeline register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ReadDataW,
  output logic        MisalignW
);

  localparam int AW = $clog2(DEPTH);

  size_e       size;
  logic [1:0]  off;
  logic        access;
  logic        load;
  logic        mis;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        sgn;
  logic        is_b;
  logic        is_h;
  mw_t         w_d;
  mw_t         w_q;

  assign off    = ALU_ResultM[1:0];
  assign access = ValidM & (MemWriteM | ResultSrcM);
  assign load   = ValidM & ResultSrcM;
  assign sgn    = ~funct3M[2];
  assign is_b   = (funct3M == F3_LB) | (funct3M == F3_LBU);
  assign is_h   = (funct3M == F3_LH) | (funct3M == F3_LHU);

  // access size; unlisted encodings fall back to word
  always_comb begin
    size = SZ_W;
    unique case (1'b1)
      is_b:    size = SZ_B;
      is_h:    size = SZ_H;
      default: size = SZ_W;
    endcase
  end

  // alignment check and store lane/data steering
  always_comb begin
    mis   = 1'b0;
    wdata = WriteDataM;
    unique case (size)
      SZ_B: begin
        mis   = 1'b0;
        wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        mis   = off[0];
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        mis   = |off;
        wdata = WriteDataM;
      end
    endcase
    mis = mis & access;
  end

  assign be = lane_mask(size, off);
  assign we = access & MemWriteM & ~mis & rst;

  data_memory #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .idx   (ALU_ResultM[AW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign sh = rdata >> {off, 3'b000};

  // byte/half extraction with sign or zero extension
  always_comb begin
    ext = sh;
    unique case (size)
      SZ_B:    ext = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_H:    ext = {{16{sgn & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  // next W bundle; bubbles and faults suppress writeback
  always_comb begin
    w_d           = '0;
    w_d.regwrite  = ValidM & RegWriteM & ~mis;
    w_d.resultsrc = ResultSrcM;
    w_d.rd        = RdM;
    w_d.alu       = ALU_ResultM;
    w_d.pc4       = PCPlus4M;
    w_d.rdata     = (load & ~mis) ? ext : 32'h0;
    w_d.misalign  = mis;
  end

  // M/W pipeline register, never stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_q <= '0;
    else      w_q <= w_d;
  end

  assign RegWriteW   = w_q.regwrite;
  assign ResultSrcW  = w_q.resultsrc;
  assign RdW         = w_q.rd;
  assign ALU_ResultW = w_q.alu;
  assign PCPlus4W    = w_q.pc4;
  assign ReadDataW   = w_q.rdata;
  assign MisalignW   = w_q.misalign;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table,
// mid-cycle reset sequence, random vs byte model.
module tb_memory_stage;

  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, ResultSrcM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteW, ResultSrcW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] ALU_ResultW, PCPlus4W, ReadDataW;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [NB];

  typedef struct {
    logic        v, rw, rs, mw;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic        erw, emis;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  memory_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidM      (ValidM),
    .RegWriteM   (RegWriteM),
    .ResultSrcM  (ResultSrcM),
    .MemWriteM   (MemWriteM),
    .funct3M     (funct3M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .RdM         (RdM),
    .PCPlus4M    (PCPlus4M),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RdW         (RdW),
    .ALU_ResultW (ALU_ResultW),
    .PCPlus4W    (PCPlus4W),
    .ReadDataW   (ReadDataW),
    .MisalignW   (MisalignW)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic v, logic rw, logic rs, logic mw, logic [2:0] f3,
    logic [31:0] a, logic [31:0] wd,
    logic erw, logic emis, logic [31:0] erd);
    vec_t t;
    t.v = v; t.rw = rw; t.rs = rs; t.mw = mw; t.f3 = f3;
    t.a = a; t.wd = wd;
    t.erw = erw; t.emis = emis; t.erd = erd;
    return t;
  endfunction

  // byte-addressed reference: size in bytes, little endian
  task automatic model(
    input logic v, rw, rs, mw, input logic [2:0] f3,
    input logic [31:0] a, wd,
    output logic erw, emis, output logic [31:0] erd);
    int n;
    int base;
    logic acc;
    logic [31:0] val;
    n = (f3 == 3'd0 || f3 == 3'd4) ? 1 :
        (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    acc  = v && (mw || rs);
    emis = acc && ((a % n) != 0);
    erw  = v && rw && !emis;
    base = int'(a % NB);
    erd  = 32'h0;
    if (v && rs && !emis) begin
      val = 0;
      for (int i = 0; i < n; i++)
        val = val | (32'(mm[base + i]) << (8 * i));
      if (n < 4 && !f3[2] && val[8*n-1])
        val = val | (32'hFFFF_FFFF << (8 * n));
      erd = val;
    end
    if (acc && mw && !emis) begin
      for (int i = 0; i < n; i++)
        mm[base + i] = wd[8*i +: 8];
    end
  endtask

  task automatic drive(
    logic v, logic rw, logic rs, logic mw, logic [2:0] f3,
    logic [31:0] a, logic [31:0] wd, logic [4:0] rd, logic [31:0] pc);
    ValidM = v; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    funct3M = f3; ALU_ResultM = a; WriteDataM = wd;
    RdM = rd; PCPlus4M = pc;
  endtask

  task automatic chk_zero(string n);
    chk({n, ".regw"}, 32'(RegWriteW), 0);
    chk({n, ".rsrc"}, 32'(ResultSrcW), 0);
    chk({n, ".rd"}, 32'(RdW), 0);
    chk({n, ".alu"}, ALU_ResultW, 0);
    chk({n, ".pc4"}, PCPlus4W, 0);
    chk({n, ".rdata"}, ReadDataW, 0);
    chk({n, ".mis"}, 32'(MisalignW), 0);
  endtask

  task automatic chk_w(string n, logic erw, logic emis, logic [31:0] erd,
                       logic rs, logic [4:0] rd, logic [31:0] a,
                       logic [31:0] pc);
    chk({n, ".regw"}, 32'(RegWriteW), 32'(erw));
    chk({n, ".mis"}, 32'(MisalignW), 32'(emis));
    chk({n, ".rdata"}, ReadDataW, erd);
    chk({n, ".rsrc"}, 32'(ResultSrcW), 32'(rs));
    chk({n, ".rd"}, 32'(RdW), 32'(rd));
    chk({n, ".alu"}, ALU_ResultW, a);
    chk({n, ".pc4"}, PCPlus4W, pc);
  endtask

  task automatic rnd_step(string n, logic v, logic rw, logic rs, logic mw,
                          logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic erw, emis;
    logic [31:0] erd;
    logic [4:0] rd;
    logic [31:0] pc;
    rd = 5'($urandom);
    pc = $urandom;
    drive(v, rw, rs, mw, f3, a, wd, rd, pc);
    model(v, rw, rs, mw, f3, a, wd, erw, emis, erd);
    @(posedge clk);
    #1;
    chk_w(n, erw, emis, erd, rs, rd, a, pc);
  endtask

  initial begin
    logic erw, emis;
    logic [31:0] erd;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk);
    #2 rst = 1'b1;

    tbl.push_back(mk(1,0,0,1,3'b010,32'h10,32'hDEADBEEF,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,3'b010,32'h10,32'h0,1,0,32'hDEADBEEF));
    tbl.push_back(mk(1,1,1,0,3'b000,32'h13,32'h0,1,0,32'hFFFFFFDE));
    tbl.push_back(mk(1,1,1,0,3'b100,32'h13,32'h0,1,0,32'h000000DE));
    tbl.push_back(mk(1,1,1,0,3'b001,32'h12,32'h0,1,0,32'hFFFFDEAD));
    tbl.push_back(mk(1,1,1,0,3'b101,32'h10,32'h0,1,0,32'h0000BEEF));
    tbl.push_back(mk(1,0,0,1,3'b000,32'h11,32'h55,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,3'b010,32'h10,32'h0,1,0,32'hDEAD55EF));
    tbl.push_back(mk(1,0,0,1,3'b010,32'h12,32'h12345678,0,1,32'h0));
    tbl.push_back(mk(1,1,1,0,3'b010,32'h10,32'h0,1,0,32'hDEAD55EF));
    tbl.push_back(mk(0,1,0,1,3'b010,32'h10,32'hCAFEF00D,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,3'b010,32'h410,32'h0,1,0,32'hDEAD55EF));
    tbl.push_back(mk(1,1,1,0,3'b010,32'h11,32'h0,0,1,32'h0));
    tbl.push_back(mk(1,1,1,0,3'b011,32'h10,32'h0,1,0,32'hDEAD55EF));
    tbl.push_back(mk(1,1,1,0,3'b001,32'h13,32'h0,0,1,32'h0));
    tbl.push_back(mk(1,1,0,0,3'b010,32'h13,32'h0,1,0,32'h0));
    tbl.push_back(mk(1,0,0,1,3'b001,32'h12,32'hFFFFA5A5,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,3'b010,32'h10,32'h0,1,0,32'hA5A555EF));
    tbl.push_back(mk(1,1,1,0,3'b001,32'h12,32'h0,1,0,32'hFFFFA5A5));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].rs, tbl[i].mw, tbl[i].f3,
            tbl[i].a, tbl[i].wd, 5'(i + 1), 32'h1000 + 32'(4 * i));
      model(tbl[i].v, tbl[i].rw, tbl[i].rs, tbl[i].mw, tbl[i].f3,
            tbl[i].a, tbl[i].wd, erw, emis, erd);
      @(posedge clk);
      #1;
      chk_w($sformatf("vec%0d", i), tbl[i].erw, tbl[i].emis, tbl[i].erd,
            tbl[i].rs, 5'(i + 1), tbl[i].a, 32'h1000 + 32'(4 * i));
    end

    drive(1, 1, 1, 0, 3'b010, 32'h10, 0, 5'd7, 32'h2000);
    #3 rst = 1'b0;
    #1 chk_zero("midrst");
    drive(1, 0, 0, 1, 3'b010, 32'h10, 32'h0BADF00D, 5'd3, 32'h2004);
    @(posedge clk);
    #1 chk_zero("inrst");
    #2 rst = 1'b1;
    drive(1, 1, 1, 0, 3'b010, 32'h10, 0, 5'd9, 32'h2008);
    @(posedge clk);
    #1 chk_w("postrst", 1, 0, 32'hA5A555EF, 1, 5'd9, 32'h10, 32'h2008);

    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | 32'(w * 4);
      rnd_step("preload", 1, 0, 0, 1, 3'b010, a, $urandom);
    end

    for (int k = 0; k < 3000; k++) begin
      int kind;
      logic v, rw, rs, mw;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      v  = ($urandom_range(0, 9) != 0);
      rs = (kind == 0);
      mw = (kind == 1);
      rw = (kind == 0) ? 1'b1 : 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rnd_step("rand", v, rw, rs, mw, f3, a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: DEPTH, 256, data memory size in 32-bit words (power of two).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: ValidM  in  1  instruction in M stage is real (0 = bubble).
REQ-005 Port: RegWriteM  in  1  instruction writes register file.
REQ-006 Port: ResultSrcM  in  1  0 = ALU result, 1 = load data selected in W.
REQ-007 Port: MemWriteM  in  1  store instruction.
REQ-008 Port: funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 Port: ALU_ResultM  in  32  effective byte address, or ALU result.
REQ-010 Port: WriteDataM  in  32  store data (low bits used for B/H).
REQ-011 Port: RdM  in  5  destination register.
REQ-012 Port: PCPlus4M  in  32  PC+4 of instruction.
REQ-013 Port: RegWriteW, ResultSrcW  out  1 each  registered copies for W stage.
REQ-014 Port: RdW  out  5; ALU_ResultW, PCPlus4W, ReadDataW  out  32 each  registered W-stage values.
REQ-015 Port: MisalignW  out  1  registered flag: instruction in W had a misaligned access.

Function
REQ-016 Memory access occurs in M when ValidM=1 and (MemWriteM=1 or ResultSrcM=1); word index = ALU_ResultM[log2(DEPTH)+1:2], upper address bits ignored (wrap).
REQ-017 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00; misaligned store SHALL NOT modify memory.
REQ-018 Store SHALL write memory at the rising edge ending the M cycle, using byte enables: SB one lane per addr[1:0], SH lanes per addr[1], SW all four; data replicated into the selected lanes.
REQ-019 Load read is combinational from current memory contents; byte/half extracted by addr[1:0], sign-extended for B/H, zero-extended for BU/HU; result registered into ReadDataW (1-cycle latency M to W).
REQ-020 Undefined funct3 on a memory access SHALL be treated as W size.
REQ-021 A store SHALL be visible to a load in the immediately following cycle.
REQ-022 Each rising edge, all W registers load from M inputs unconditionally (no stall).
REQ-023 When ValidM=0: RegWriteW<=0, MisalignW<=0, no memory write; other W registers load their inputs.
REQ-024 When misaligned: RegWriteW<=0, MisalignW<=1, ReadDataW<=0.
REQ-025 Non-load instructions: ReadDataW<=0.

Reset
REQ-026 rst=0 SHALL immediately clear all W outputs to 0, independent of clk.
REQ-027 Memory array contents SHALL NOT be reset; a store coinciding with asserted reset SHALL NOT be performed.
REQ-028 After rst deasserts, the first rising edge captures M inputs normally.

Structure
REQ-029 Shared package: funct3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) and default DEPTH.
REQ-030 One sub-module, data_memory: byte-enabled synchronous write, combinational read, DEPTH words; extraction/extension and pipeline register live in memory_stage.

Verification
REQ-031 SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> ReadDataW=0xDEADBEEF, RegWriteW=1, MisalignW=0.
REQ-032 After REQ-031, LB 0x13 -> ReadDataW=0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SB 0x55 to 0x11 then LW 0x10 -> 0xDEAD55EF.
REQ-034 SW 0x12345678 to 0x12 (misaligned) -> MisalignW=1, RegWriteW=0; LW 0x10 still 0xDEAD55EF.
REQ-035 ValidM=0 with MemWriteM=1, RegWriteM=1 -> memory unchanged, RegWriteW=0; addr 0x410 (DEPTH=256) aliases to 0x10.
REQ-036 Assert rst mid-stream between clock edges -> all W outputs 0 immediately; previously stored word still readable after release.
